dmi_jtag_dr: RTL and testbench

Downstream data-register stage of the DMI JTAG TAP: implements the DTMCS and DMI data registers (debug spec 0.13) in the TCK domain and converts completed DMI scans into valid/ready request/response transactions toward the Debug Module (CDC lives downstream). It consumes the TAP's capture/shift/update strobes, TDI and DR selects, and returns per-register TDO bits.

---
 rtl/dmi_pkg.sv | 36 +++
 rtl/dmi_jtag_dr.sv | 171 +++++++++++++++++
 tb/tb_dmi_jtag_dr.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared types and constants for the DMI JTAG data-register stage.
package dmi_pkg;

   typedef enum logic [1:0] {
      DtmNop   = 2'd0,
      DtmRead  = 2'd1,
      DtmWrite = 2'd2,
      DtmBusy  = 2'd3
   } dtm_op_e;

   typedef enum logic [1:0] {
      RespSuccess = 2'd0,
      RespFailed  = 2'd2,
      RespBusy    = 2'd3
   } dmi_resp_e;

   typedef struct packed {
      logic [13:0] zero1;
      logic        dmihardreset;
      logic        dmireset;
      logic        zero0;
      logic [2:0]  idle;
      logic [1:0]  dmistat;
      logic [5:0]  abits;
      logic [3:0]  version;
   } dtmcs_t;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp
   } dr_state_e;

   localparam logic [3:0] DtmcsVersion = 4'd1;

endpackage

// File: rtl/dmi_jtag_dr.sv
// DTMCS and DMI data registers in the TCK domain; turns completed DMI scans into
// valid/ready request/response transactions toward the Debug Module.
module dmi_jtag_dr
   import dmi_pkg::*;
#(
   parameter int unsigned AbitsDmi   = 7,
   parameter logic [2:0]  IdleCycles = 3'd1
) (
   input  logic                tck_i,
   input  logic                trst_i,
   input  logic                dmi_clear_i,
   input  logic                capture_i,
   input  logic                shift_i,
   input  logic                update_i,
   input  logic                tdi_i,
   input  logic                dtmcs_select_i,
   input  logic                dmi_select_i,
   output logic                dtmcs_tdo_o,
   output logic                dmi_tdo_o,
   output logic                dmi_req_valid_o,
   input  logic                dmi_req_ready_i,
   output logic [AbitsDmi-1:0] dmi_req_addr_o,
   output logic [1:0]          dmi_req_op_o,
   output logic [31:0]         dmi_req_data_o,
   input  logic                dmi_resp_valid_i,
   output logic                dmi_resp_ready_o,
   input  logic [31:0]         dmi_resp_data_i,
   input  logic [1:0]          dmi_resp_resp_i,
   output logic                dmi_hardreset_o
);

   localparam int unsigned DmiWidth = AbitsDmi + 34;

   dr_state_e             state_q, state_d;
   logic [1:0]            error_q, error_d;
   logic [AbitsDmi-1:0]   addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic [1:0]            op_q, op_d;
   logic [31:0]           dtmcs_shift_q, dtmcs_shift_d;
   logic [DmiWidth-1:0]   dmi_shift_q, dmi_shift_d;
   logic                  req_valid_q, req_valid_d;
   logic                  resp_ready_q, resp_ready_d;
   logic                  hardreset_q, hardreset_d;
   logic                  busy;
   logic [1:0]            capture_op;
   logic [1:0]            scan_op;
   dtmcs_t                dtmcs_rd;

   always_comb begin
      dtmcs_rd         = '0;
      dtmcs_rd.idle    = IdleCycles;
      dtmcs_rd.dmistat = error_q;
      dtmcs_rd.abits   = 6'(AbitsDmi);
      dtmcs_rd.version = DtmcsVersion;

      state_d       = state_q;
      error_d       = error_q;
      addr_d        = addr_q;
      data_d        = data_q;
      op_d          = op_q;
      dtmcs_shift_d = dtmcs_shift_q;
      dmi_shift_d   = dmi_shift_q;
      hardreset_d   = 1'b0;

      busy       = (state_q != StIdle);
      capture_op = (busy && error_q == 2'd0) ? DtmBusy : error_q;
      scan_op    = dmi_shift_q[1:0];

      unique case (state_q)
         StReq: begin
            if (dmi_req_ready_i) state_d = StResp;
         end
         StResp: begin
            if (dmi_resp_valid_i) begin
               state_d = StIdle;
               if (op_q == DtmRead) data_d = dmi_resp_data_i;
               if (dmi_resp_resp_i == RespFailed && error_q == 2'd0) error_d = RespFailed;
            end
         end
         default: ;
      endcase

      if (capture_i && dtmcs_select_i) begin
         dtmcs_shift_d = dtmcs_rd;
      end else if (shift_i && dtmcs_select_i) begin
         dtmcs_shift_d = {tdi_i, dtmcs_shift_q[31:1]};
      end

      // A capture racing a response completion reports busy, so the sticky error
      // must agree with the op the host just shifted out.
      if (capture_i && dmi_select_i) begin
         dmi_shift_d = {addr_q, data_q, capture_op};
         if (busy && error_q == 2'd0) error_d = DtmBusy;
      end else if (shift_i && dmi_select_i) begin
         dmi_shift_d = {tdi_i, dmi_shift_q[DmiWidth-1:1]};
      end

      if (update_i && dmi_select_i && error_q == 2'd0) begin
         if (busy) begin
            error_d = DtmBusy;
         end else begin
            addr_d = dmi_shift_q[DmiWidth-1 -: AbitsDmi];
            op_d   = scan_op;
            if (scan_op == DtmRead || scan_op == DtmWrite) begin
               data_d  = dmi_shift_q[33:2];
               state_d = StReq;
            end
         end
      end

      if (update_i && dtmcs_select_i) begin
         if (dtmcs_shift_q[17]) begin
            state_d     = StIdle;
            error_d     = 2'd0;
            hardreset_d = 1'b1;
         end else if (dtmcs_shift_q[16]) begin
            error_d = 2'd0;
         end
      end

      if (dmi_clear_i) begin
         state_d       = StIdle;
         error_d       = '0;
         addr_d        = '0;
         data_d        = '0;
         op_d          = '0;
         dtmcs_shift_d = '0;
         dmi_shift_d   = '0;
         hardreset_d   = 1'b0;
      end

      req_valid_d  = (state_d == StReq);
      resp_ready_d = (state_d == StResp);
   end

   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         state_q       <= StIdle;
         error_q       <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         op_q          <= '0;
         dtmcs_shift_q <= '0;
         dmi_shift_q   <= '0;
         req_valid_q   <= 1'b0;
         resp_ready_q  <= 1'b0;
         hardreset_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         error_q       <= error_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         op_q          <= op_d;
         dtmcs_shift_q <= dtmcs_shift_d;
         dmi_shift_q   <= dmi_shift_d;
         req_valid_q   <= req_valid_d;
         resp_ready_q  <= resp_ready_d;
         hardreset_q   <= hardreset_d;
      end
   end

   assign dtmcs_tdo_o      = dtmcs_shift_q[0];
   assign dmi_tdo_o        = dmi_shift_q[0];
   assign dmi_req_valid_o  = req_valid_q;
   assign dmi_req_addr_o   = addr_q;
   assign dmi_req_op_o     = op_q;
   assign dmi_req_data_o   = data_q;
   assign dmi_resp_ready_o = resp_ready_q;
   assign dmi_hardreset_o  = hardreset_q;

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed bench for dmi_jtag_dr: JTAG scans via tasks, hand-computed expectations.
module tb_dmi_jtag_dr;

   localparam int unsigned AW = 7;
   localparam int unsigned W  = AW + 34;

   logic          tck = 1'b0;
   logic          trst = 1'b0;
   logic          dmi_clear = 1'b0;
   logic          capture = 1'b0, shift = 1'b0, update = 1'b0, tdi = 1'b0;
   logic          dtmcs_sel = 1'b0, dmi_sel = 1'b0;
   logic          dtmcs_tdo, dmi_tdo;
   logic          req_valid, req_ready = 1'b0;
   logic [AW-1:0] req_addr;
   logic [1:0]    req_op;
   logic [31:0]   req_data;
   logic          resp_valid = 1'b0, resp_ready;
   logic [31:0]   resp_data = '0;
   logic [1:0]    resp_resp = '0;
   logic          hardreset;

   int n_cmp = 0;
   int n_err = 0;

   dmi_jtag_dr #(.AbitsDmi(AW), .IdleCycles(3'd1)) dut (
      .tck_i            (tck),
      .trst_i           (trst),
      .dmi_clear_i      (dmi_clear),
      .capture_i        (capture),
      .shift_i          (shift),
      .update_i         (update),
      .tdi_i            (tdi),
      .dtmcs_select_i   (dtmcs_sel),
      .dmi_select_i     (dmi_sel),
      .dtmcs_tdo_o      (dtmcs_tdo),
      .dmi_tdo_o        (dmi_tdo),
      .dmi_req_valid_o  (req_valid),
      .dmi_req_ready_i  (req_ready),
      .dmi_req_addr_o   (req_addr),
      .dmi_req_op_o     (req_op),
      .dmi_req_data_o   (req_data),
      .dmi_resp_valid_i (resp_valid),
      .dmi_resp_ready_o (resp_ready),
      .dmi_resp_data_i  (resp_data),
      .dmi_resp_resp_i  (resp_resp),
      .dmi_hardreset_o  (hardreset)
   );

   always #5 tck = ~tck;

   task automatic step();
      @(posedge tck);
      #1;
   endtask

   task automatic dtmcs_scan(input logic [31:0] din, output logic [31:0] dout);
      dout = '0;
      dtmcs_sel = 1'b1; capture = 1'b1; step(); capture = 1'b0; shift = 1'b1;
      for (int i = 0; i < 32; i++) begin
         dout[i] = dtmcs_tdo; tdi = din[i]; step();
      end
      shift = 1'b0; update = 1'b1; step(); update = 1'b0; dtmcs_sel = 1'b0; tdi = 1'b0;
   endtask

   task automatic dmi_scan(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] o,
                           output logic [AW-1:0] ca, output logic [31:0] cd,
                           output logic [1:0] co);
      logic [W-1:0] vin, vout;
      vin = {a, d, o}; vout = '0;
      dmi_sel = 1'b1; capture = 1'b1; step(); capture = 1'b0; shift = 1'b1;
      for (int i = 0; i < W; i++) begin
         vout[i] = dmi_tdo; tdi = vin[i]; step();
      end
      shift = 1'b0; update = 1'b1; step(); update = 1'b0; dmi_sel = 1'b0; tdi = 1'b0;
      {ca, cd, co} = vout;
   endtask

   task automatic test_reset();
      trst = 1'b1; step(); step();
      n_cmp++; if ({req_valid, resp_ready, hardreset, dtmcs_tdo, dmi_tdo} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctl: got %b want 00000",
                           {req_valid, resp_ready, hardreset, dtmcs_tdo, dmi_tdo});
      end
      n_cmp++; if ({req_addr, req_op, req_data} !== '0) begin
         n_err++; $display("FAIL reset_payload: got %h want 0", {req_addr, req_op, req_data});
      end
      trst = 1'b0; step();
   endtask

   task automatic test_dtmcs_read();
      logic [31:0] v;
      dtmcs_scan(32'h0, v);
      n_cmp++; if (v !== 32'h0000_1071) begin
         n_err++; $display("FAIL dtmcs_read: got %h want 00001071", v);
      end
   endtask

   task automatic test_write_stall();
      logic [AW-1:0] ca; logic [31:0] cd; logic [1:0] co;
      req_ready = 1'b0;
      dmi_scan(7'h10, 32'hDEAD_BEEF, 2'd2, ca, cd, co);
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if ({req_valid, req_addr, req_op, req_data} !== {1'b1, 7'h10, 2'd2, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL write_hold[%0d]: got %h want 1/10/2/deadbeef", c,
                              {req_valid, req_addr, req_op, req_data});
         end
         if (c < 2) step();
      end
      req_ready = 1'b1; step(); req_ready = 1'b0;
      n_cmp++; if ({req_valid, resp_ready} !== 2'b01) begin
         n_err++; $display("FAIL write_resp_state: got %b want 01", {req_valid, resp_ready});
      end
      resp_valid = 1'b1; resp_data = 32'hAAAA_5555; resp_resp = 2'd0; step(); resp_valid = 1'b0;
      n_cmp++; if (resp_ready !== 1'b0) begin
         n_err++; $display("FAIL write_done: got resp_ready %b want 0", resp_ready);
      end
      dmi_scan(7'h00, 32'h0, 2'd0, ca, cd, co);
      n_cmp++; if ({ca, cd, co} !== {7'h10, 32'hDEAD_BEEF, 2'd0}) begin
         n_err++; $display("FAIL write_capture: got %h want 10/deadbeef/0", {ca, cd, co});
      end
      n_cmp++; if (req_valid !== 1'b0) begin
         n_err++; $display("FAIL nop_no_req: got valid %b want 0", req_valid);
      end
   endtask

   task automatic test_read();
      logic [AW-1:0] ca; logic [31:0] cd; logic [1:0] co;
      req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'h1234_5678; resp_resp = 2'd0;
      dmi_scan(7'h11, 32'h0, 2'd1, ca, cd, co);
      n_cmp++; if ({req_valid, req_op} !== 3'b101) begin
         n_err++; $display("FAIL read_req: got %b want 101", {req_valid, req_op});
      end
      step();
      n_cmp++; if ({req_valid, resp_ready} !== 2'b01) begin
         n_err++; $display("FAIL read_resp: got %b want 01", {req_valid, resp_ready});
      end
      step();
      n_cmp++; if ({req_valid, resp_ready} !== 2'b00) begin
         n_err++; $display("FAIL read_idle: got %b want 00", {req_valid, resp_ready});
      end
      req_ready = 1'b0; resp_valid = 1'b0;
      dmi_scan(7'h00, 32'h0, 2'd0, ca, cd, co);
      n_cmp++; if ({ca, cd, co} !== {7'h11, 32'h1234_5678, 2'd0}) begin
         n_err++; $display("FAIL read_capture: got %h want 11/12345678/0", {ca, cd, co});
      end
   endtask

   task automatic test_busy();
      logic [AW-1:0] ca; logic [31:0] cd; logic [1:0] co; logic [31:0] v;
      dmi_scan(7'h12, 32'h55, 2'd2, ca, cd, co);
      req_ready = 1'b1; step(); req_ready = 1'b0;
      dmi_scan(7'h13, 32'h1, 2'd2, ca, cd, co);
      n_cmp++; if (co !== 2'd3) begin
         n_err++; $display("FAIL busy_capture_op: got %0d want 3", co);
      end
      n_cmp++; if ({req_valid, resp_ready, req_addr} !== {2'b01, 7'h12}) begin
         n_err++; $display("FAIL busy_update_ignored: got %h want 1/12",
                           {req_valid, resp_ready, req_addr});
      end
      resp_valid = 1'b1; resp_resp = 2'd0; step(); resp_valid = 1'b0;
      dtmcs_scan(32'h0001_0000, v);
      n_cmp++; if (v !== 32'h0000_1C71) begin
         n_err++; $display("FAIL busy_dmistat: got %h want 00001c71", v);
      end
      dtmcs_scan(32'h0, v);
      n_cmp++; if (v !== 32'h0000_1071) begin
         n_err++; $display("FAIL dmireset_clear: got %h want 00001071", v);
      end
   endtask

   task automatic test_failed_hardreset();
      logic [AW-1:0] ca; logic [31:0] cd; logic [1:0] co; logic [31:0] v;
      req_ready = 1'b1; resp_valid = 1'b1; resp_resp = 2'd2; resp_data = 32'h0;
      dmi_scan(7'h14, 32'h0, 2'd1, ca, cd, co);
      step(); step();
      resp_valid = 1'b0; resp_resp = 2'd0;
      dtmcs_scan(32'h0, v);
      n_cmp++; if (v !== 32'h0000_1871) begin
         n_err++; $display("FAIL failed_dmistat: got %h want 00001871", v);
      end
      dmi_scan(7'h15, 32'h9, 2'd2, ca, cd, co);
      n_cmp++; if (co !== 2'd2) begin
         n_err++; $display("FAIL failed_capture_op: got %0d want 2", co);
      end
      n_cmp++; if ({req_valid, req_addr} !== {1'b0, 7'h14}) begin
         n_err++; $display("FAIL failed_ignored: got %h want 0/14", {req_valid, req_addr});
      end
      req_ready = 1'b0;
      dtmcs_scan(32'h0002_0000, v);
      n_cmp++; if (hardreset !== 1'b1) begin
         n_err++; $display("FAIL hardreset_pulse: got %b want 1", hardreset);
      end
      step();
      n_cmp++; if (hardreset !== 1'b0) begin
         n_err++; $display("FAIL hardreset_end: got %b want 0", hardreset);
      end
      dtmcs_scan(32'h0, v);
      n_cmp++; if (v !== 32'h0000_1071) begin
         n_err++; $display("FAIL hardreset_dmistat: got %h want 00001071", v);
      end
   endtask

   task automatic test_hardreset_mid();
      logic [AW-1:0] ca; logic [31:0] cd; logic [1:0] co; logic [31:0] v;
      req_ready = 1'b0;
      dmi_scan(7'h17, 32'h77, 2'd2, ca, cd, co);
      n_cmp++; if ({co, req_valid} !== 3'b001) begin
         n_err++; $display("FAIL post_hr_req: got op %0d valid %b want 0/1", co, req_valid);
      end
      dtmcs_scan(32'h0002_0000, v);
      n_cmp++; if ({hardreset, req_valid, resp_ready} !== 3'b100) begin
         n_err++; $display("FAIL hr_mid_abandon: got %b want 100", {hardreset, req_valid, resp_ready});
      end
      step();
      dmi_scan(7'h00, 32'h0, 2'd0, ca, cd, co);
      n_cmp++; if (co !== 2'd0) begin
         n_err++; $display("FAIL hr_mid_idle: got op %0d want 0", co);
      end
   endtask

   task automatic test_clear();
      logic [AW-1:0] ca; logic [31:0] cd; logic [1:0] co;
      req_ready = 1'b0;
      dmi_scan(7'h16, 32'hCAFE_F00D, 2'd2, ca, cd, co);
      n_cmp++; if (req_valid !== 1'b1) begin
         n_err++; $display("FAIL clear_pre: got valid %b want 1", req_valid);
      end
      dmi_clear = 1'b1; req_ready = 1'b1; step(); dmi_clear = 1'b0; req_ready = 1'b0;
      n_cmp++; if ({req_valid, resp_ready, req_addr, req_op, req_data, dmi_tdo} !== '0) begin
         n_err++; $display("FAIL clear_state: got %h want 0",
                           {req_valid, resp_ready, req_addr, req_op, req_data, dmi_tdo});
      end
      dmi_scan(7'h00, 32'h0, 2'd0, ca, cd, co);
      n_cmp++; if ({ca, cd, co} !== '0) begin
         n_err++; $display("FAIL clear_capture: got %h want 0", {ca, cd, co});
      end
   endtask

   initial begin
      test_reset();
      test_dtmcs_read();
      test_write_stall();
      test_read();
      test_busy();
      test_failed_hardreset();
      test_hardreset_mid();
      test_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
